// File: rtl/gpio_link_pkg.sv
// Shared constants for the GPIO byte link:
// register offsets, register bit positions and handshake states.
package gpio_link_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERRUN  = 2;
  localparam int ST_COUNT_LSB = 4;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_UND = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_ACKED
  } link_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy count.
// A pop in the same cycle lets a push land even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpio_byte_link.sv
// GPIO byte receiver: REQ/ACK handshake into a FIFO,
// drained by the CPU through DATA/STATUS/CTRL registers.
module gpio_byte_link
  import gpio_link_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic        i_bus_DV,
  input  logic [3:0]  i_bus_address,
  input  logic [31:0] i_bus_data,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  input  logic [7:0]  i_gpio_data,
  input  logic [3:0]  i_gpio_control,
  output logic [3:0]  o_gpio_control
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0]      r_req_sync;
  logic [SYNC_STAGES-1:0][7:0] r_dat_sync;
  link_state_e                 r_state;
  logic                        r_ack;
  logic                        r_und;
  logic                        r_bus_dv;
  logic [31:0]                 r_bus_data;

  logic          w_req;
  logic [7:0]    w_byte;
  logic          w_bus_req;
  logic          w_rd;
  logic          w_wr;
  logic          w_pop;
  logic          w_flush;
  logic          w_clr_und;
  logic          w_push;
  logic          w_can_push;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = ^{i_bhw, i_bus_data[31:2], i_gpio_control[3:1]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_req_sync <= '0;
      r_dat_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], i_gpio_control[0]};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_gpio_data};
    end
  end

  assign w_req  = r_req_sync[SYNC_STAGES-1];
  assign w_byte = r_dat_sync[SYNC_STAGES-1];

  assign w_bus_req = i_bus_DV & i_sel;
  assign w_rd      = w_bus_req & ~i_write_notread;
  assign w_wr      = w_bus_req & i_write_notread;
  assign w_pop     = w_rd & (i_bus_address == ADDR_DATA) & ~w_empty;
  assign w_flush   = w_wr & (i_bus_address == ADDR_CTRL)
                   & i_bus_data[CTRL_FLUSH];
  assign w_clr_und = w_wr & (i_bus_address == ADDR_CTRL)
                   & i_bus_data[CTRL_CLR_UND];

  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign w_can_push = ~w_full | w_pop;
  assign w_push = w_can_push
                & (((r_state == S_IDLE) & w_req) | (r_state == S_STALL));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_byte),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_can_push) begin
              r_ack   <= 1'b1;
              r_state <= S_ACKED;
            end else begin
              r_state <= S_STALL;
            end
          end
        end
        S_STALL: begin
          if (w_can_push) begin
            r_ack   <= 1'b1;
            r_state <= S_ACKED;
          end
        end
        S_ACKED: begin
          if (!w_req) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_bus_address)
      ADDR_DATA: begin
        if (!w_empty) w_rdata[7:0] = w_head;
      end
      ADDR_STATUS: begin
        w_rdata[ST_NOT_EMPTY]         = ~w_empty;
        w_rdata[ST_FULL]              = w_full;
        w_rdata[ST_UNDERRUN]          = r_und;
        w_rdata[ST_COUNT_LSB +: CW]   = w_count;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bus_dv   <= 1'b0;
      r_bus_data <= '0;
      r_und      <= 1'b0;
    end else begin
      r_bus_dv   <= w_bus_req;
      r_bus_data <= w_rd ? w_rdata : '0;
      if (w_rd && (i_bus_address == ADDR_DATA) && w_empty) begin
        r_und <= 1'b1;
      end else if (w_clr_und) begin
        r_und <= 1'b0;
      end
    end
  end

  assign o_bus_DV       = r_bus_dv;
  assign o_bus_data     = r_bus_data;
  assign o_gpio_control = {2'b00, ~w_empty, r_ack};

endmodule
